// File: rtl/athos_result_queue.sv
// rtl/athos_result_queue.sv - in-order XIF result buffer with per-id commit/kill scoreboard
// Optional output register: define ATHOS_RESULT_QUEUE_OUT_REG_EN.
module athos_result_queue #(
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_valid_i,
    output logic                    push_ready_o,
    input  logic [ID_WIDTH-1:0]     push_id_i,
    input  logic [4:0]              push_rd_i,
    input  logic [1:0]              push_we_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic                    commit_valid_i,
    input  logic [ID_WIDTH-1:0]     commit_id_i,
    input  logic                    commit_kill_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [ID_WIDTH-1:0]     result_id_o,
    output logic [4:0]              result_rd_o,
    output logic [1:0]              result_we_o,
    output logic [DATA_WIDTH-1:0]   result_data_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int NID = 2 ** ID_WIDTH;

    logic [ID_WIDTH-1:0]   id_q   [DEPTH];
    logic [4:0]            rd_q   [DEPTH];
    logic [1:0]            we_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic [NID-1:0] c_q, k_q, c_d, k_d;

    logic full, empty, push_fire, pop, take;
    logic head_commit, head_kill, dup_id;
    logic [ID_WIDTH-1:0] head_id;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign push_ready_o = !full;
    assign push_fire    = push_valid_i && !full;
    assign count_o      = count_q;

    assign head_id     = id_q[rd_ptr_q];
    assign head_kill   = !empty && k_q[head_id];
    assign head_commit = !empty && c_q[head_id] && !k_q[head_id];
    assign pop         = take || head_kill;

    // Retiring clears the id after any same-cycle commit, so a late event for it is dropped.
    always_comb begin
        c_d = c_q;
        k_d = k_q;
        if (commit_valid_i) begin
            if (commit_kill_i) k_d[commit_id_i] = 1'b1;
            else               c_d[commit_id_i] = 1'b1;
        end
        if (pop) begin
            c_d[head_id] = 1'b0;
            k_d[head_id] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            c_q      <= '0;
            k_q      <= '0;
        end else begin
            c_q <= c_d;
            k_q <= k_d;
            if (push_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)       rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_fire, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push_fire) begin
            id_q[wr_ptr_q]   <= push_id_i;
            rd_q[wr_ptr_q]   <= push_rd_i;
            we_q[wr_ptr_q]   <= push_we_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

`ifdef ATHOS_RESULT_QUEUE_OUT_REG_EN
    logic                  ov_q;
    logic [ID_WIDTH-1:0]   oid_q;
    logic [4:0]            ord_q;
    logic [1:0]            owe_q;
    logic [DATA_WIDTH-1:0] odata_q;

    assign take = head_commit && (!ov_q || result_ready_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ov_q    <= 1'b0;
            oid_q   <= '0;
            ord_q   <= '0;
            owe_q   <= '0;
            odata_q <= '0;
        end else if (take) begin
            ov_q    <= 1'b1;
            oid_q   <= head_id;
            ord_q   <= rd_q[rd_ptr_q];
            owe_q   <= we_q[rd_ptr_q];
            odata_q <= data_q[rd_ptr_q];
        end else if (result_ready_i) begin
            ov_q <= 1'b0;
        end
    end

    assign result_valid_o = ov_q;
    assign result_id_o    = ov_q ? oid_q   : '0;
    assign result_rd_o    = ov_q ? ord_q   : '0;
    assign result_we_o    = ov_q ? owe_q   : '0;
    assign result_data_o  = ov_q ? odata_q : '0;
`else
    assign take = head_commit && result_ready_i;

    assign result_valid_o = head_commit;
    assign result_id_o    = head_commit ? head_id          : '0;
    assign result_rd_o    = head_commit ? rd_q[rd_ptr_q]   : '0;
    assign result_we_o    = head_commit ? we_q[rd_ptr_q]   : '0;
    assign result_data_o  = head_commit ? data_q[rd_ptr_q] : '0;
`endif

    // Upstream must never push an id that is still resident.
    always_comb begin
        dup_id = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (id_q[rd_ptr_q + PW'(i)] == push_id_i)) dup_id = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push_fire) assert (!dup_id);
    end
endmodule

// File: doc/athos_result_queue.md
Name: athos_result_queue

Overview:
- Result buffer between the ATHOS datapath output and the XIF result interface.
- Each completed instruction's dual-register result (rd1/rd2 packed) is pushed here with its XIF instruction id.
- Commit/kill information from the XIF commit channel is tracked per id.
- Committed results are presented in push order on a valid/ready result port; killed results are silently discarded.

Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥2).
- ID_WIDTH, 4, width of XIF instruction id; scoreboard has 2**ID_WIDTH slots.
- DATA_WIDTH, 64, result payload width (rd2 in [63:32], rd1 in [31:0]).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- push_valid_i  input  1  datapath result available.
- push_ready_o  output  1  queue can accept a push.
- push_id_i  input  ID_WIDTH  id of pushed result.
- push_rd_i  input  5  destination register.
- push_we_i  input  2  write-enable per 32-bit half.
- push_data_i  input  DATA_WIDTH  result payload.
- commit_valid_i  input  1  commit/kill event.
- commit_id_i  input  ID_WIDTH  id being committed/killed.
- commit_kill_i  input  1  1 = kill, 0 = commit.
- result_valid_o  output  1  committed head result valid.
- result_ready_i  input  1  core accepts result.
- result_id_o  output  ID_WIDTH  head id.
- result_rd_o  output  5  head rd.
- result_we_o  output  2  head we.
- result_data_o  output  DATA_WIDTH  head payload.
- count_o  output  $clog2(DEPTH)+1  entries currently stored.

Behaviour:
- Reset: rd/wr pointers = 0, count_o = 0, all scoreboard committed/killed bits = 0.
- Outputs after reset: push_ready_o = 1, result_valid_o = 0; result_id/rd/we/data = 0.
- Storage: circular buffer; pointers wrap modulo DEPTH; full when count = DEPTH.
- Push acceptance: push_ready_o = !full, independent of same-cycle pop. A full queue never accepts a push, even if a pop occurs that cycle.
- Push transfer: occurs when push_valid_i && push_ready_o. Entry is written and wr pointer advances at the edge.
- Scoreboard: per id, committed bit C and killed bit K.
  - commit_valid_i sets C (commit_kill_i = 0) or K (commit_kill_i = 1) for commit_id_i.
  - Commit may arrive before or after the matching push.
- Head evaluation is combinational from registered state:
  - Head is committed when C = 1 and K = 0.
  - Head is killed when K = 1; kill wins if both are set.
  - result_valid_o = !empty && head committed.
  - result_* outputs show head fields when valid, 0 otherwise.
- Pop:
  - Committed head pops on result_valid_o && result_ready_i.
  - Killed head pops automatically in the cycle it is at head, with no result_valid_o.
  - On either pop, the scoreboard C/K for that id are cleared at the same edge.
  - A commit event for the same id in that cycle is ignored, since that id is retired.
- Latency: push at edge N with id already committed, queue empty → result_valid_o high during cycle N+1. Commit arriving after push → result_valid_o high the cycle after the commit edge.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Ordering: strictly push order. A non-committed, non-killed head blocks younger entries.
- Upstream guarantees an id is not pushed again while resident. Behaviour for duplicates is unspecified; an assertion flags it.
- result_valid_o, once high, holds with stable payload until result_ready_i.
- Reset mid-operation discards all entries and scoreboard state at the next edge.

Optional Feature:
- Macro: ATHOS_RESULT_QUEUE_OUT_REG_EN.
- Defined:
  - Result port is driven from a one-entry output register.
  - Head moves into the register when it is empty or being drained; this adds 1 cycle latency.
  - Back-to-back throughput stays at 1 result per cycle.
  - count_o excludes the output register.
  - Reset clears the register valid bit.
- Undefined: combinational head output as described above.

Test Plan:
- Commit before push: commit id 3, then push id 3 (rd 5, we 2'b11, data 64'h0000_0002_0000_0001) into empty queue → next cycle result_valid_o = 1 with id 3, rd 5, data matching. With result_ready_i = 1 the queue empties; count_o returns to 0.
- Commit after push, in order: push ids 1, 2 with result_ready_i = 1; commit 2 first, then 1 two cycles later → id 1 is output the cycle after commit 1, then id 2 the next cycle.
- Kill drop: push ids 4, 5; kill 4, commit 5 → id 4 never appears on result_valid_o; id 5 is output; count_o steps 2 → 1 → 0.
- Full/backpressure: result_ready_i = 0, push DEPTH = 4 committed entries → push_ready_o = 0, count_o = 4. A 5th push is not accepted; the queue is unchanged while ready_i stays low.
- Simultaneous push/pop at count 2: one push plus one result handshake in the same cycle → count_o stays 2 and ordering is preserved.
- Reset mid-operation: with 3 entries and committed bits set, drive rst_ni = 0 for one edge → count_o = 0, result_valid_o = 0. A subsequent push of a previously committed id waits for a new commit.
